// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - sequencer between the CPU and the multiply/divide units
//
// Accepts one multiply or divide request at a time, latches the operands for
// the units, fires a one-cycle start pulse, waits the unit latency and then
// copies the selected unit's result into the architectural HI/LO registers.
//
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   op_start, op_sel            request strobe, 0 = multiply / 1 = divide
//   srcA, srcB                  request operands (srcB is the divisor)
//   multCtrl, divCtrl           one-cycle start pulses to the units
//   unitA, unitB                latched operands driven to both units
//   mult_hi/lo, div_hi/lo       unit results (div_hi = remainder, div_lo = quotient)
//   hi, lo                      architectural HI/LO registers
//   busy, done, divZero         stall flag, completion pulse, divide-by-zero pulse
module muldiv_ctrl #(
  parameter int N_BITS   = 32,
  parameter int MULT_LAT = 32,
  parameter int DIV_LAT  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_start,
  input  logic              op_sel,
  input  logic [N_BITS-1:0] srcA,
  input  logic [N_BITS-1:0] srcB,
  output logic              multCtrl,
  output logic              divCtrl,
  output logic [N_BITS-1:0] unitA,
  output logic [N_BITS-1:0] unitB,
  input  logic [N_BITS-1:0] mult_hi,
  input  logic [N_BITS-1:0] mult_lo,
  input  logic [N_BITS-1:0] div_hi,
  input  logic [N_BITS-1:0] div_lo,
  output logic [N_BITS-1:0] hi,
  output logic [N_BITS-1:0] lo,
  output logic              busy,
  output logic              done,
  output logic              divZero
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              sel_q, sel_nxt;
  logic [N_BITS-1:0] unit_a_nxt, unit_b_nxt, hi_nxt, lo_nxt;
  logic              busy_nxt, done_nxt, div_zero_nxt, mult_ctrl_nxt, div_ctrl_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      sel_q    <= 1'b0;
      unitA    <= '0;
      unitB    <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      divZero  <= 1'b0;
      multCtrl <= 1'b0;
      divCtrl  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      sel_q    <= sel_nxt;
      unitA    <= unit_a_nxt;
      unitB    <= unit_b_nxt;
      hi       <= hi_nxt;
      lo       <= lo_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      divZero  <= div_zero_nxt;
      multCtrl <= mult_ctrl_nxt;
      divCtrl  <= div_ctrl_nxt;
    end
  end

  // Every output is registered, so the start strobe is computed on the
  // accepting edge and is therefore high during the START cycle itself.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    sel_nxt       = sel_q;
    unit_a_nxt    = unitA;
    unit_b_nxt    = unitB;
    hi_nxt        = hi;
    lo_nxt        = lo;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    div_zero_nxt  = 1'b0;
    mult_ctrl_nxt = 1'b0;
    div_ctrl_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (op_start) begin
          if (op_sel && (srcB == '0)) begin
            // rejected divide: nothing is started and HI/LO stay as they are
            div_zero_nxt = 1'b1;
          end else begin
            unit_a_nxt    = srcA;
            unit_b_nxt    = srcB;
            sel_nxt       = op_sel;
            busy_nxt      = 1'b1;
            mult_ctrl_nxt = ~op_sel;
            div_ctrl_nxt  = op_sel;
            state_nxt     = START;
          end
        end
      end

      START: begin
        cnt_nxt   = sel_q ? DIV_LOAD : MULT_LOAD;
        state_nxt = WAIT;
      end

      WAIT: begin
        if (cnt == '0) begin
          hi_nxt    = sel_q ? div_hi : mult_hi;
          lo_nxt    = sel_q ? div_lo : mult_lo;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;

  localparam int N  = 32;
  localparam int ML = 32;
  localparam int DL = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         op_start, op_sel;
  logic [N-1:0] srcA, srcB;
  logic         multCtrl, divCtrl;
  logic [N-1:0] unitA, unitB;
  logic [N-1:0] mult_hi, mult_lo, div_hi, div_lo;
  logic [N-1:0] hi, lo;
  logic         busy, done, divZero;

  int n_chk  = 0;
  int n_pass = 0;
  int both_bad = 0;
  logic [N-1:0] hi_m = '0;
  logic [N-1:0] lo_m = '0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.N_BITS(N), .MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .reset(reset), .op_start(op_start), .op_sel(op_sel),
    .srcA(srcA), .srcB(srcB), .multCtrl(multCtrl), .divCtrl(divCtrl),
    .unitA(unitA), .unitB(unitB), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_hi(div_hi), .div_lo(div_lo), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .divZero(divZero)
  );

  function automatic logic [63:0] f_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic signed [63:0] x, y;
    x = $signed(a);
    y = $signed(b);
    return x * y;
  endfunction

  // {remainder, quotient}, signed
  function automatic logic [63:0] f_div(input logic [N-1:0] a, input logic [N-1:0] b);
    int sa, sb, q, r;
    sa = a;
    sb = b;
    if (sb == 0) return 64'd0;
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Unit models: result is only valid LAT cycles after the start pulse,
  // otherwise the inverted value is presented so an early sample shows up.
  int m_cnt = 0;
  int d_cnt = 0;
  logic [63:0] m_res, d_res;
  always @(posedge clk) begin
    if (multCtrl) m_cnt <= ML - 1; else if (m_cnt > 0) m_cnt <= m_cnt - 1;
    if (divCtrl)  d_cnt <= DL - 1; else if (d_cnt > 0) d_cnt <= d_cnt - 1;
  end
  always_comb begin
    m_res = f_mul(unitA, unitB);
    d_res = f_div(unitA, unitB);
    if (m_cnt != 0) m_res = ~m_res;
    if (d_cnt != 0) d_res = ~d_res;
  end
  assign mult_hi = m_res[63:32];
  assign mult_lo = m_res[31:0];
  assign div_hi  = d_res[63:32];
  assign div_lo  = d_res[31:0];

  always @(negedge clk) if (multCtrl && divCtrl) both_bad++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_multCtrl"}, multCtrl, 0);
    check({tag, "_divCtrl"},  divCtrl, 0);
    check({tag, "_busy"},     busy, 0);
    check({tag, "_done"},     done, 0);
    check({tag, "_divZero"},  divZero, 0);
    check({tag, "_hi"},       hi, 0);
    check({tag, "_lo"},       lo, 0);
    check({tag, "_unitA"},    unitA, 0);
    check({tag, "_unitB"},    unitB, 0);
  endtask

  // Issue one request and observe the window that follows. Ends at the
  // cycle where done should be high, so the next call's request lands in
  // the done cycle. collide >= 0 injects a second request while busy.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic sel, input int collide);
    int lat, win, done_k, n_done, n_m, n_d, m_k, d_k, n_dz, dz_k;
    int busy_bad, unit_bad, hl_bad;
    logic dz;
    logic [63:0] r;
    logic [N-1:0] eh, el;
    dz  = sel && (b == 0);
    lat = sel ? DL : ML;
    win = dz ? 3 : lat + 2;
    r   = sel ? f_div(a, b) : f_mul(a, b);
    eh  = dz ? hi_m : r[63:32];
    el  = dz ? lo_m : r[31:0];
    done_k = -1; n_done = 0; n_m = 0; n_d = 0; m_k = -1; d_k = -1;
    n_dz = 0; dz_k = -1; busy_bad = 0; unit_bad = 0; hl_bad = 0;

    srcA = a; srcB = b; op_sel = sel; op_start = 1'b1;
    @(posedge clk); #1;
    op_start = 1'b0; srcA = $urandom; srcB = $urandom; op_sel = $urandom;
    for (int k = 0; k < win; k++) begin
      if (done) begin n_done++; if (done_k < 0) done_k = k; end
      if (multCtrl) begin n_m++; m_k = k; end
      if (divCtrl) begin n_d++; d_k = k; end
      if (divZero) begin n_dz++; dz_k = k; end
      if (busy !== (!dz && k <= lat)) busy_bad++;
      if (!dz && k <= lat && (unitA !== a || unitB !== b)) unit_bad++;
      if (k < win - 1 && (hi !== hi_m || lo !== lo_m)) hl_bad++;
      if (k == collide) begin
        op_start = 1'b1; op_sel = $urandom; srcA = 190; srcB = 13;
      end else begin
        op_start = 1'b0;
      end
      if (k < win - 1) begin @(posedge clk); #1; end
    end

    check("done_cycle",     done_k, dz ? -1 : lat + 1);
    check("done_count",     n_done, dz ? 0 : 1);
    check("mult_pulses",    n_m, (!dz && !sel) ? 1 : 0);
    check("div_pulses",     n_d, (!dz && sel) ? 1 : 0);
    check("pulse_cycle",    sel ? d_k : m_k, dz ? -1 : 0);
    check("divzero_pulses", n_dz, dz ? 1 : 0);
    check("divzero_cycle",  dz_k, dz ? 0 : -1);
    check("busy_profile",   busy_bad, 0);
    check("unit_stable",    unit_bad, 0);
    check("hilo_held",      hl_bad, 0);
    check("hi",             hi, eh);
    check("lo",             lo, el);
    hi_m = eh;
    lo_m = el;
  endtask

  task automatic reset_mid(input int at);
    int n_done;
    srcA = $urandom; srcB = $urandom | 1; op_sel = $urandom; op_start = 1'b1;
    @(posedge clk); #1;
    op_start = 1'b0;
    for (int k = 1; k < at; k++) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check_zero("mid_reset");
    n_done = 0;
    for (int k = 0; k < ML + 8; k++) begin
      @(posedge clk); #1;
      if (done || busy || hi !== 0 || lo !== 0) n_done++;
    end
    check("quiet_after_reset", n_done, 0);
    hi_m = '0;
    lo_m = '0;
  endtask

  initial begin
    logic [N-1:0] a, b;
    logic sel;
    int coll;
    reset = 1'b0; op_start = 1'b0; op_sel = 1'b0; srcA = '0; srcB = '0;
    @(posedge clk); #1;
    // reset wins over a simultaneous request
    op_start = 1'b1; srcA = 32'h1234; srcB = 32'h5;
    @(posedge clk); #1;
    op_start = 1'b0;
    check_zero("reset");
    reset = 1'b1;

    run_op(32'hFFFF_FFE8, 32'd6, 1'b1, -1);
    run_op(32'd190, 32'd13, 1'b1, -1);
    run_op(32'd7, 32'd6, 1'b0, -1);
    run_op(32'd5, 32'd0, 1'b1, -1);
    run_op(32'd1234, 32'd5678, 1'b0, 9);
    reset_mid(15);
    run_op(32'd190, 32'd13, 1'b1, -1);

    for (int i = 0; i < 30; i++) begin
      a   = $urandom;
      b   = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 40);
      sel = $urandom_range(0, 1);
      if ($urandom_range(0, 4) == 0) begin b = '0; sel = 1'b1; end
      if (b == 32'hFFFF_FFFF) b = 32'd3;
      coll = ($urandom_range(0, 2) == 0 && !(sel && b == 0)) ? $urandom_range(0, 31) : -1;
      for (int g = $urandom_range(0, 2); g > 0; g--) begin @(posedge clk); #1; end
      run_op(a, b, sel, coll);
    end

    check("strobes_exclusive", both_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter N_BITS, default 32, operand/result width.
REQ-002 SHALL have parameter MULT_LAT, default 32, cycles from mult start pulse to valid mult result.
REQ-003 SHALL have parameter DIV_LAT, default 32, cycles from div start pulse to valid div result.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset (reset==0 at a rising edge resets the block).
REQ-006 op_start  input  1  request strobe from the control unit, sampled each edge.
REQ-007 op_sel  input  1  0 = multiply, 1 = divide; qualified by op_start.
REQ-008 srcA, srcB  input  N_BITS each  operands; srcB is the divisor.
REQ-009 multCtrl, divCtrl  output  1 each  one-cycle start pulses to the mult and div units.
REQ-010 unitA, unitB  output  N_BITS each  latched operands driven to both units.
REQ-011 mult_hi, mult_lo, div_hi, div_lo  input  N_BITS each  unit results (div_hi = remainder, div_lo = quotient).
REQ-012 hi, lo  output  N_BITS each  architectural HI/LO registers (MFHI/MFLO source).
REQ-013 busy  output  1  high while an operation is in flight; CPU stalls on it.
REQ-014 done  output  1  one-cycle pulse: hi/lo just updated.
REQ-015 divZero  output  1  one-cycle pulse: divide request with srcB==0 rejected.

Function
REQ-016 SHALL implement states IDLE, START, WAIT; all outputs registered.
REQ-017 IDLE: op_start==1 with valid operation SHALL latch srcA/srcB into unitA/unitB, latch op_sel, go to START, set busy next cycle.
REQ-018 START (one cycle): SHALL assert multCtrl (op_sel 0) or divCtrl (op_sel 1) for exactly this cycle; load counter with selected LAT-1; go to WAIT.
REQ-019 WAIT: SHALL decrement counter each cycle; at counter==0 edge SHALL write hi/lo from selected unit results, set done for one cycle, clear busy, return to IDLE.
REQ-020 Latency: request accepted at edge T -> start pulse in cycle T+1 -> done high and new hi/lo visible in cycle T+LAT+2 (34 cycles after acceptance at defaults).
REQ-021 Counter SHALL be wide enough for max(MULT_LAT, DIV_LAT)-1 (6 bits at defaults); no wrap below 0.
REQ-022 Divide with srcB==0 in IDLE SHALL NOT start the divider, SHALL pulse divZero the next cycle, leave hi/lo unchanged, keep busy low, stay IDLE.
REQ-023 op_start while busy (START/WAIT) SHALL be ignored: no queueing, no operand change, no strobe.
REQ-024 op_start in the cycle done is high (state IDLE) SHALL be accepted normally.
REQ-025 multCtrl and divCtrl SHALL never be high in the same cycle; at most one pulse per accepted request.
REQ-026 unitA/unitB SHALL hold stable from acceptance until return to IDLE.
REQ-027 hi/lo SHALL change only on done or reset; all result bits copied verbatim (no sign handling in this block).

Reset
REQ-028 reset==0 at an edge SHALL force state IDLE, counter 0, busy/done/divZero/multCtrl/divCtrl 0, hi/lo/unitA/unitB 0, from any state including mid-WAIT.
REQ-029 After reset aborts an operation, no done pulse and no hi/lo write SHALL occur for it; late unit results are ignored.
REQ-030 Reset SHALL take priority over a simultaneous op_start.

Verification
REQ-031 Divide: srcA=-24 (0xFFFFFFE8), srcB=6, op_sel=1, unit model returns div_hi=0, div_lo=0xFFFFFFFC -> divCtrl one pulse at T+1, done at T+34, hi=0, lo=0xFFFFFFFC.
REQ-032 Divide: srcA=190, srcB=13 -> done at T+34, hi=8, lo=14; multCtrl stays 0 throughout.
REQ-033 Multiply: srcA=7, srcB=6, op_sel=0, model mult_hi=0, mult_lo=42 -> multCtrl one pulse, done at T+34, hi=0, lo=42.
REQ-034 Divide by zero: srcA=5, srcB=0 -> divZero pulse at T+1, divCtrl never high, busy stays 0, hi/lo keep prior values (0, 42).
REQ-035 Busy collision: second op_start (190/13 div) at T+10 during a multiply -> ignored; single done at T+34 with multiply result; unitA/unitB unchanged.
REQ-036 Reset mid-WAIT: reset low at T+15 for one edge -> all outputs 0 next cycle, no done thereafter; new request after reset completes normally.
